// File: rtl/signal_pkg.sv
// -----------------------------------------------------------------------------
// signal_pkg
// Shared encodings for the multi-phase intersection controller.
//   LIGHT_*   : 2-bit per-approach lamp encoding (red=0, yellow=1, green=2)
//   phase_state_e : controller state for the phase holding the right of way
//   lightFor  : lamp shown by the active phase in a given controller state
// -----------------------------------------------------------------------------
package signal_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2
    } phase_state_e;

    // All-red shows red on the active approach as well as on every other one.
    function automatic logic [1:0] lightFor(input phase_state_e st);
        logic [1:0] lamp;
        case (st)
            ST_GREEN:  lamp = LIGHT_GREEN;
            ST_YELLOW: lamp = LIGHT_YELLOW;
            default:   lamp = LIGHT_RED;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/phase_rr_select.sv
// -----------------------------------------------------------------------------
// phase_rr_select
// Combinational round-robin picker. Starting just after the current phase and
// wrapping modulo NUM_PHASES, returns the first phase with pending demand.
// Ports:
//   pending_i [NUM_PHASES] : latched demand per phase
//   current_i [PH_W]       : phase currently holding the right of way
//   next_o    [PH_W]       : first pending phase after current_i (0 if none)
//   valid_o                : high when any phase is pending
// -----------------------------------------------------------------------------
module phase_rr_select #(
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] pending_i,
    input  logic [PH_W-1:0]       current_i,
    output logic [PH_W-1:0]       next_o,
    output logic                  valid_o
);

    // Scan from the farthest offset down to the nearest so the closest pending
    // phase after current_i is the one left standing; this avoids a break.
    always_comb begin
        int idx;
        idx     = 0;
        next_o  = '0;
        valid_o = 1'b0;
        for (int k = NUM_PHASES; k >= 1; k--) begin
            idx = (int'(current_i) + k) % NUM_PHASES;
            if (pending_i[idx]) begin
                next_o  = PH_W'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_phase_signal_control.sv
// -----------------------------------------------------------------------------
// multi_phase_signal_control
// Sensor-actuated controller for NUM_PHASES approaches. Phase 0 (main road)
// rests green when nobody else waits; other phases are served round-robin
// with minimum/maximum green, yellow and all-red clearance.
// Ports:
//   clk          : rising-edge clock
//   clr          : asynchronous active-high reset, discards all demand
//   req          : per-phase vehicle sensor (level or one-cycle pulse)
//   lights       : per-phase lamp, phase i in bits [2i+1:2i]
//   active_phase : phase owning the right of way
//   phase_state  : GREEN=0, YELLOW=1, ALL_RED=2
//   green_start  : one-cycle pulse in the first green cycle of a phase
// -----------------------------------------------------------------------------
module multi_phase_signal_control
    import signal_pkg::*;
#(
    parameter int NUM_PHASES   = 4,
    parameter int CNT_W        = 8,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 16,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int PH_W         = $clog2(NUM_PHASES)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [NUM_PHASES-1:0]   req,
    output logic [2*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         active_phase,
    output logic [1:0]              phase_state,
    output logic                    green_start
);

    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [2*NUM_PHASES-1:0] LIGHTS_RESET =
        {{(2*NUM_PHASES-2){1'b0}}, LIGHT_GREEN};

    phase_state_e            state_q, state_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic [NUM_PHASES-1:0]   pending_q, pending_d;
    logic [PH_W-1:0]         activePhase_q, activePhase_d;
    logic [PH_W-1:0]         nextPhase_q, nextPhase_d;
    logic [2*NUM_PHASES-1:0] lights_q, lights_d;
    logic                    greenStart_q, greenStart_d;

    logic [NUM_PHASES-1:0]   activeMask;
    logic                    reqActive;
    logic                    othersWaiting;
    logic                    greenExit;
    logic                    enterGreen;
    logic [PH_W-1:0]         rrNext;
    logic                    rrValid;

    phase_rr_select #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_rr (
        .pending_i (pending_q),
        .current_i (activePhase_q),
        .next_o    (rrNext),
        .valid_o   (rrValid)
    );

    // Decode the active phase into a mask and pick out its own sensor; done
    // with a loop so a non-power-of-two phase count never indexes off the end.
    always_comb begin
        activeMask = '0;
        reqActive  = 1'b0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (activePhase_q == PH_W'(i)) begin
                activeMask[i] = 1'b1;
                reqActive     = req[i];
            end
        end
        othersWaiting = |(pending_q & ~activeMask);
    end

    // Max-out uses >= so a demand that shows up after the active phase has
    // already run past MAX_GREEN (e.g. main road resting with its sensor held)
    // is still served instead of being starved.
    always_comb begin
        greenExit = 1'b0;
        if (timer_q >= MIN_LAST) begin
            if (othersWaiting && (!reqActive || timer_q >= MAX_LAST)) begin
                greenExit = 1'b1;
            end else if ((activePhase_q != '0) && !reqActive && !othersWaiting) begin
                greenExit = 1'b1;
            end
        end
    end

    // Next-state logic: the timer restarts on every state entry and otherwise
    // saturates. next_phase is captured once at the green exit and held.
    always_comb begin
        state_d       = state_q;
        timer_d       = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        activePhase_d = activePhase_q;
        nextPhase_d   = nextPhase_q;
        enterGreen    = 1'b0;
        case (state_q)
            ST_GREEN: begin
                if (greenExit) begin
                    state_d     = ST_YELLOW;
                    timer_d     = '0;
                    nextPhase_d = rrValid ? rrNext : '0;
                end
            end
            ST_YELLOW: begin
                if (timer_q == YELLOW_LAST) begin
                    state_d = ST_ALL_RED;
                    timer_d = '0;
                end
            end
            ST_ALL_RED: begin
                if (timer_q == ALLRED_LAST) begin
                    state_d       = ST_GREEN;
                    timer_d       = '0;
                    activePhase_d = nextPhase_q;
                    enterGreen    = 1'b1;
                end
            end
            default: begin
                state_d = ST_GREEN;
                timer_d = '0;
            end
        endcase
        greenStart_d = enterGreen;
    end

    // Demand latch: the active green phase ignores its own sensor, and the
    // clear on green entry wins over a simultaneous set.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (enterGreen && (nextPhase_q == PH_W'(i))) begin
                pending_d[i] = 1'b0;
            end else if (req[i] && !(activeMask[i] && state_q == ST_GREEN)) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    // Lamps are computed from the next state so the registered lights line up
    // with phase_state and green_start in the same cycle.
    always_comb begin
        lights_d = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            lights_d[2*i +: 2] = (activePhase_d == PH_W'(i)) ? lightFor(state_d)
                                                             : LIGHT_RED;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= ST_GREEN;
            timer_q       <= '0;
            pending_q     <= '0;
            activePhase_q <= '0;
            nextPhase_q   <= '0;
            lights_q      <= LIGHTS_RESET;
            greenStart_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            activePhase_q <= activePhase_d;
            nextPhase_q   <= nextPhase_d;
            lights_q      <= lights_d;
            greenStart_q  <= greenStart_d;
        end
    end

    assign lights       = lights_q;
    assign active_phase = activePhase_q;
    assign phase_state  = state_q;
    assign green_start  = greenStart_q;

endmodule

// File: tb/tb_multi_phase_signal_control.sv
// -----------------------------------------------------------------------------
// tb_multi_phase_signal_control
// Directed, self-checking bench for the default 4-phase configuration.
// A table of per-cycle vectors covers the basic service sequences; hand-written
// sequences cover max-out, simultaneous demand and clear during yellow.
// -----------------------------------------------------------------------------
module tb_multi_phase_signal_control;

    localparam logic [1:0] S_G  = 2'd0;
    localparam logic [1:0] S_Y  = 2'd1;
    localparam logic [1:0] S_AR = 2'd2;

    typedef struct {
        logic [3:0] req;
        logic [7:0] lights;
        logic [1:0] state;
        logic [1:0] phase;
        logic       gs;
    } vec_t;

    logic       clk;
    logic       clr;
    logic [3:0] req;
    logic [7:0] lights;
    logic [1:0] active_phase;
    logic [1:0] phase_state;
    logic       green_start;

    int   checks;
    int   errors;
    vec_t vecs[$];

    multi_phase_signal_control dut (
        .clk          (clk),
        .clr          (clr),
        .req          (req),
        .lights       (lights),
        .active_phase (active_phase),
        .phase_state  (phase_state),
        .green_start  (green_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something below never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
        tick();
    endtask

    function automatic void addRun(input int n, input logic [3:0] r,
                                   input logic [7:0] l, input logic [1:0] s,
                                   input logic [1:0] p, input logic g);
        vec_t v;
        v.req = r; v.lights = l; v.state = s; v.phase = p; v.gs = g;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic doReset();
        clr = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        checkOutput("reset.lights", 32'(lights), 32'h02);
        checkOutput("reset.state", 32'(phase_state), 32'(S_G));
        checkOutput("reset.phase", 32'(active_phase), 32'd0);
        checkOutput("reset.green_start", 32'(green_start), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Waits for the next green_start pulse, then checks which phase got it.
    task automatic waitGreen(input string name, input logic [1:0] expPhase,
                             input logic [7:0] expLights);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!green_start && n < 200);
        if (!green_start) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout waiting for green_start", name);
        end else begin
            checkOutput({name, ".phase"}, 32'(active_phase), 32'(expPhase));
            checkOutput({name, ".lights"}, 32'(lights), 32'(expLights));
        end
    endtask

    initial begin
        int gcount;
        int n;
        checks = 0;
        errors = 0;
        clr    = 1'b1;
        req    = 4'b0000;
        #12;

        // Idle main road: phase 0 rests green for 50 cycles.
        doReset();
        for (int i = 0; i < 50; i++) begin
            applyStimulus(4'b0000);
            checkOutput($sformatf("idle[%0d].lights", i), 32'(lights), 32'h02);
            checkOutput($sformatf("idle[%0d].state", i), 32'(phase_state), 32'(S_G));
            checkOutput($sformatf("idle[%0d].phase", i), 32'(active_phase), 32'd0);
        end

        // req[1] from the first cycle after reset, then a req[2] pulse later.
        addRun(1, 4'b0010, 8'h02, S_G,  2'd0, 1'b0);
        addRun(2, 4'b0000, 8'h02, S_G,  2'd0, 1'b0);
        addRun(3, 4'b0000, 8'h01, S_Y,  2'd0, 1'b0);
        addRun(2, 4'b0000, 8'h00, S_AR, 2'd0, 1'b0);
        addRun(1, 4'b0000, 8'h08, S_G,  2'd1, 1'b1);
        addRun(3, 4'b0000, 8'h08, S_G,  2'd1, 1'b0);
        addRun(3, 4'b0000, 8'h04, S_Y,  2'd1, 1'b0);
        addRun(2, 4'b0000, 8'h00, S_AR, 2'd1, 1'b0);
        addRun(1, 4'b0000, 8'h02, S_G,  2'd0, 1'b1);
        addRun(5, 4'b0000, 8'h02, S_G,  2'd0, 1'b0);
        addRun(1, 4'b0100, 8'h02, S_G,  2'd0, 1'b0);
        addRun(3, 4'b0000, 8'h01, S_Y,  2'd0, 1'b0);
        addRun(2, 4'b0000, 8'h00, S_AR, 2'd0, 1'b0);
        addRun(1, 4'b0000, 8'h20, S_G,  2'd2, 1'b1);
        addRun(3, 4'b0000, 8'h20, S_G,  2'd2, 1'b0);
        addRun(3, 4'b0000, 8'h10, S_Y,  2'd2, 1'b0);
        addRun(2, 4'b0000, 8'h00, S_AR, 2'd2, 1'b0);
        addRun(1, 4'b0000, 8'h02, S_G,  2'd0, 1'b1);

        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req);
            checkOutput($sformatf("vec[%0d].lights", i), 32'(lights), 32'(vecs[i].lights));
            checkOutput($sformatf("vec[%0d].state", i), 32'(phase_state), 32'(vecs[i].state));
            checkOutput($sformatf("vec[%0d].phase", i), 32'(active_phase), 32'(vecs[i].phase));
            checkOutput($sformatf("vec[%0d].gs", i), 32'(green_start), 32'(vecs[i].gs));
        end

        // Max-out: phase 1 held by its sensor while phase 3 waits.
        req = 4'b0010;
        waitGreen("maxout.p1", 2'd1, 8'h08);
        gcount = 1;
        applyStimulus(4'b1010);
        req = 4'b0010;
        while (lights == 8'h08 && gcount < 100) begin
            gcount++;
            tick();
        end
        req = 4'b0000;
        checkOutput("maxout.green_cycles", 32'(gcount), 32'd16);
        checkOutput("maxout.yellow_lights", 32'(lights), 32'h04);
        waitGreen("maxout.p3", 2'd3, 8'h80);
        waitGreen("maxout.p0", 2'd0, 8'h02);

        // Simultaneous demand on phases 1 and 3 while phase 0 rests.
        for (int i = 0; i < 5; i++) applyStimulus(4'b0000);
        applyStimulus(4'b1010);
        req = 4'b0000;
        waitGreen("simul.p1", 2'd1, 8'h08);
        waitGreen("simul.p3", 2'd3, 8'h80);
        waitGreen("simul.p0", 2'd0, 8'h02);

        // Clear mid-yellow of phase 2 with phase 3 still pending.
        for (int i = 0; i < 5; i++) applyStimulus(4'b0000);
        applyStimulus(4'b0100);
        applyStimulus(4'b1000);
        req = 4'b0000;
        waitGreen("clr.p2", 2'd2, 8'h20);
        n = 0;
        while (phase_state != S_Y && n < 100) begin
            tick();
            n++;
        end
        checkOutput("clr.yellow_lights", 32'(lights), 32'h10);
        #2;
        clr = 1'b1;
        #1;
        checkOutput("clr.async_lights", 32'(lights), 32'h02);
        checkOutput("clr.async_state", 32'(phase_state), 32'(S_G));
        checkOutput("clr.async_phase", 32'(active_phase), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(4'b0000);
            checkOutput($sformatf("clr.rest[%0d].phase", i), 32'(active_phase), 32'd0);
            checkOutput($sformatf("clr.rest[%0d].lights", i), 32'(lights), 32'h02);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
